spi_slave_core: RTL and testbench
=================================

Name: spi_slave_core

Overview:
- SPI mode-0 slave; the far-end partner of the SPI master stage, attached to SCLK/CS_n/MOSI/MISO on the slave FPGA.
- Oversamples SCLK with the system clock, deserialises MOSI into WIDTH-bit words and serialises TX words onto MISO.
- Uses valid/ready handshakes toward the slave-side RX and TX FIFOs.
- Supports back-to-back words within one CS_n frame.

Parameters:
- WIDTH, 8: bits per SPI word, MSB first; legal range 2..32.
- FILL, 8'hFF: word shifted out on MISO when no TX word is available (tx underrun); truncated or zero-extended to WIDTH.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- sclk  in  1  SPI clock; already 2-flop synchronised upstream (sync module).
- cs_n  in  1  chip select, active low; already synchronised upstream.
- mosi  in  1  master-out data; already synchronised upstream.
- miso  out  1  slave-out data.
- miso_oe  out  1  MISO tristate enable; equals registered ~cs_n.
- rx_data  out  WIDTH  last received word.
- rx_valid  out  1  rx_data holds an unconsumed word.
- rx_ready  in  1  consumer accepts rx_data.
- tx_data  in  WIDTH  next word to send.
- tx_valid  in  1  tx_data is available.
- tx_ready  out  1  one-cycle pulse: tx_data consumed.
- rx_overrun  out  1  one-cycle pulse: a new word overwrote an unconsumed rx_data.
- tx_underrun  out  1  one-cycle pulse: a FILL word was committed.
- frame_err  out  1  one-cycle pulse: CS_n deasserted mid-word.
- busy  out  1  frame active (state != IDLE).

Behaviour:
- Reset values: miso=FILL[WIDTH-1], miso_oe=0, rx_data=0, rx_valid=0, tx_ready=0, rx_overrun=0, tx_underrun=0, frame_err=0, busy=0, bit_cnt=0, state=IDLE.
- Timing requirement: SCLK high and low phases must each be ≥4 clk cycles. Faster SCLK is unsupported.
- Edge detection: sclk_d is the registered sclk.
  - rise = sclk & ~sclk_d; fall = ~sclk & sclk_d.
  - cs_fall and cs_rise are derived from cs_n the same way.
- States: IDLE, ACTIVE.
- IDLE:
  - On cs_fall: load tx_shreg from tx_data if tx_valid, else from FILL.
  - Record src_fifo = tx_valid; drive miso = loaded MSB; bit_cnt=0; go to ACTIVE.
  - sclk edges while in IDLE are ignored.
- ACTIVE, on rise (sample):
  - rx_shreg <= {rx_shreg[WIDTH-2:0], mosi}; bit_cnt++.
  - If bit_cnt==0, commit the current TX word: pulse tx_ready if src_fifo, else pulse tx_underrun.
  - If bit_cnt==WIDTH-1: rx_data <= {rx_shreg[WIDTH-2:0], mosi}; rx_valid <= 1; bit_cnt <= 0.
  - If rx_valid was already 1 without a handshake in the same cycle, also pulse rx_overrun.
- ACTIVE, on fall (shift):
  - If bit_cnt==0 and at least one word has completed in this frame, load the next word from tx_data/FILL, re-record src_fifo and drive its MSB.
  - Otherwise shift tx_shreg left and drive the new MSB.
- TX commit point: the load→commit gap means a word loaded on the trailing SCLK fall is NOT consumed if CS_n rises first.
- TX stability: tx_data must stay stable while tx_valid=1 and tx_ready=0.
- rx_valid handshake:
  - rx_valid & rx_ready clears rx_valid next cycle.
  - If a word completes in the same cycle as the handshake, rx_valid stays 1 with the new data and there is no overrun.
- cs_rise in ACTIVE:
  - If bit_cnt != 0, pulse frame_err and discard the partial RX bits; rx_data is unchanged.
  - In all cases go to IDLE with miso_oe=0.
  - cs_rise takes priority over a coincident sclk edge.
- rst asserted mid-frame: immediate return to reset values. A word loaded but not yet committed is not consumed.

Decomposition:
- Shared package spi_pkg:
  - state enum spi_slave_state_t {IDLE, ACTIVE};
  - localparam SPI_MODE=0.
- One sub-module, edge_detect (per-signal registered rise/fall pulses), instantiated for sclk and cs_n.

Test Plan:
- Single frame, WIDTH=8, tx_valid=1, tx_data=8'hA5, master sends 8'h3C → miso bit sequence 1,0,1,0,0,1,0,1; rx_data=8'h3C with rx_valid; one tx_ready pulse at the first SCLK rise.
- Back-to-back frame: 3 words 8'h01, 8'h02, 8'h03 with rx_ready held at 1 → three rx_valid words in order; TX FIFO supplying 8'h10, 8'h11, 8'h12 gives exactly three tx_ready pulses, and the trailing fall load is not consumed.
- tx_valid=0 for the whole frame → miso outputs 8'hFF; exactly one tx_underrun pulse per word; tx_ready never asserted.
- rx_ready=0, two words received → rx_data holds the second word; one rx_overrun pulse.
- cs_n raised after 5 bits → one frame_err pulse; rx_valid stays 0; busy=0 and miso_oe=0 within 2 cycles of the synchronised cs_n rise.
- rst pulsed for 1 cycle mid-word → all outputs at reset values next cycle; no tx_ready if the word was uncommitted; the next frame completes normally.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI slave datapath.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package spi_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } spi_slave_state_t;

    // Clock polarity/phase: CPOL=0, CPHA=0 (sample on rise, shift on fall).
    localparam int SPI_MODE = 0;

endpackage

// File: rtl/edge_detect.sv
// Registered single-signal edge detector producing rise/fall pulses.
// Latency: pulses are combinational against the one-cycle-delayed copy.
// Backpressure: none; pulses are one clk wide and never held.
module edge_detect #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic sig,
    output logic rise,
    output logic fall
);

    logic sig_q;
    logic sig_d;

    // Next value of the delayed copy is simply the current input.
    always_comb begin
        sig_d = sig;
    end

    // Delay register; reset to the signal's idle level so no edge fires out of reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            sig_q <= RST_VAL;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign rise = sig & ~sig_q;
    assign fall = ~sig & sig_q;

endmodule

// File: rtl/spi_slave_core.sv
// SPI mode-0 slave: deserialises MOSI into words, serialises TX words onto MISO.
// Latency: rx word valid one clk after the last SCLK rise is seen; MISO updates one clk after SCLK fall.
// Backpressure: rx side never stalls (overwrite + rx_overrun); empty tx side sends FILL (tx_underrun).
module spi_slave_core
    import spi_pkg::*;
#(
    parameter int          WIDTH = 8,
    parameter logic [31:0] FILL  = 32'h0000_00FF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sclk,
    input  logic             cs_n,
    input  logic             mosi,
    output logic             miso,
    output logic             miso_oe,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_valid,
    input  logic             rx_ready,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic             rx_overrun,
    output logic             tx_underrun,
    output logic             frame_err,
    output logic             busy
);

    localparam int               CW     = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] FILL_W = FILL[WIDTH-1:0];
    localparam logic [CW-1:0]    LAST   = CW'(WIDTH - 1);

    logic sclk_rise, sclk_fall, cs_rise, cs_fall;

    edge_detect #(.RST_VAL(1'b0)) u_sclk_edge (
        .clk  (clk),
        .rst  (rst),
        .sig  (sclk),
        .rise (sclk_rise),
        .fall (sclk_fall)
    );

    edge_detect #(.RST_VAL(1'b1)) u_cs_edge (
        .clk  (clk),
        .rst  (rst),
        .sig  (cs_n),
        .rise (cs_rise),
        .fall (cs_fall)
    );

    spi_slave_state_t state_q, state_d;
    logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
    logic [WIDTH-1:0] tx_shreg_q, tx_shreg_d;
    logic [WIDTH-1:0] rx_shreg_q, rx_shreg_d;
    logic [WIDTH-1:0] rx_data_q, rx_data_d;
    logic             rx_valid_q, rx_valid_d;
    logic             src_fifo_q, src_fifo_d;
    logic             word_done_q, word_done_d;
    logic             miso_q, miso_d;
    logic             miso_oe_q, miso_oe_d;
    logic             tx_ready_q, tx_ready_d;
    logic             tx_underrun_q, tx_underrun_d;
    logic             rx_overrun_q, rx_overrun_d;
    logic             frame_err_q, frame_err_d;
    logic [WIDTH-1:0] next_word;

    // A word is captured for transmit at load time; it only counts as consumed at its first SCLK rise.
    assign next_word = tx_valid ? tx_data : FILL_W;

    // Frame FSM plus shift/count datapath; cs_rise outranks any coincident SCLK edge.
    always_comb begin
        state_d       = state_q;
        bit_cnt_d     = bit_cnt_q;
        tx_shreg_d    = tx_shreg_q;
        rx_shreg_d    = rx_shreg_q;
        rx_data_d     = rx_data_q;
        rx_valid_d    = rx_valid_q;
        src_fifo_d    = src_fifo_q;
        word_done_d   = word_done_q;
        miso_d        = miso_q;
        miso_oe_d     = ~cs_n;
        tx_ready_d    = 1'b0;
        tx_underrun_d = 1'b0;
        rx_overrun_d  = 1'b0;
        frame_err_d   = 1'b0;

        if (rx_valid_q && rx_ready) begin
            rx_valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (cs_fall) begin
                    tx_shreg_d  = next_word;
                    src_fifo_d  = tx_valid;
                    miso_d      = next_word[WIDTH-1];
                    bit_cnt_d   = '0;
                    word_done_d = 1'b0;
                    state_d     = ACTIVE;
                end
            end
            ACTIVE: begin
                if (cs_rise) begin
                    frame_err_d = (bit_cnt_q != '0);
                    bit_cnt_d   = '0;
                    word_done_d = 1'b0;
                    state_d     = IDLE;
                end else if (sclk_rise) begin
                    rx_shreg_d = {rx_shreg_q[WIDTH-2:0], mosi};
                    bit_cnt_d  = bit_cnt_q + CW'(1);
                    if (bit_cnt_q == '0) begin
                        tx_ready_d    = src_fifo_q;
                        tx_underrun_d = ~src_fifo_q;
                    end
                    if (bit_cnt_q == LAST) begin
                        rx_data_d    = rx_shreg_d;
                        rx_valid_d   = 1'b1;
                        rx_overrun_d = rx_valid_q & ~rx_ready;
                        bit_cnt_d    = '0;
                        word_done_d  = 1'b1;
                    end
                end else if (sclk_fall) begin
                    if (bit_cnt_q == '0 && word_done_q) begin
                        tx_shreg_d = next_word;
                        src_fifo_d = tx_valid;
                        miso_d     = next_word[WIDTH-1];
                    end else begin
                        tx_shreg_d = tx_shreg_q << 1;
                        miso_d     = tx_shreg_q[WIDTH-2];
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            bit_cnt_q     <= '0;
            tx_shreg_q    <= '0;
            rx_shreg_q    <= '0;
            rx_data_q     <= '0;
            rx_valid_q    <= 1'b0;
            src_fifo_q    <= 1'b0;
            word_done_q   <= 1'b0;
            miso_q        <= FILL_W[WIDTH-1];
            miso_oe_q     <= 1'b0;
            tx_ready_q    <= 1'b0;
            tx_underrun_q <= 1'b0;
            rx_overrun_q  <= 1'b0;
            frame_err_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            bit_cnt_q     <= bit_cnt_d;
            tx_shreg_q    <= tx_shreg_d;
            rx_shreg_q    <= rx_shreg_d;
            rx_data_q     <= rx_data_d;
            rx_valid_q    <= rx_valid_d;
            src_fifo_q    <= src_fifo_d;
            word_done_q   <= word_done_d;
            miso_q        <= miso_d;
            miso_oe_q     <= miso_oe_d;
            tx_ready_q    <= tx_ready_d;
            tx_underrun_q <= tx_underrun_d;
            rx_overrun_q  <= rx_overrun_d;
            frame_err_q   <= frame_err_d;
        end
    end

    assign miso        = miso_q;
    assign miso_oe     = miso_oe_q;
    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign tx_ready    = tx_ready_q;
    assign tx_underrun = tx_underrun_q;
    assign rx_overrun  = rx_overrun_q;
    assign frame_err   = frame_err_q;
    assign busy        = (state_q == ACTIVE);

endmodule

// File: tb/tb_spi_slave_core.sv
// Directed bench for spi_slave_core: bench acts as SPI master, TX FIFO and RX consumer.
// Latency: n/a.
// Backpressure: rx_ready driven per scenario; TX FIFO modelled as a queue popped on tx_ready.
module tb_spi_slave_core;

    localparam int W = 8;
    localparam int H = 6;  // SCLK half period in clk cycles

    logic         clk = 1'b0;
    logic         rst;
    logic         sclk;
    logic         cs_n;
    logic         mosi;
    logic         miso;
    logic         miso_oe;
    logic [W-1:0] rx_data;
    logic         rx_valid;
    logic         rx_ready;
    logic [W-1:0] tx_data;
    logic         tx_valid;
    logic         tx_ready;
    logic         rx_overrun;
    logic         tx_underrun;
    logic         frame_err;
    logic         busy;

    int total = 0;
    int bad   = 0;
    int n_rdy = 0, n_und = 0, n_ovr = 0, n_ferr = 0;
    int rdy_pre, rdy_post;
    logic [7:0] tx_q[$];
    logic [7:0] rx_got[$];

    spi_slave_core #(.WIDTH(W), .FILL(32'h0000_00FF)) dut (
        .clk         (clk),
        .rst         (rst),
        .sclk        (sclk),
        .cs_n        (cs_n),
        .mosi        (mosi),
        .miso        (miso),
        .miso_oe     (miso_oe),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .rx_overrun  (rx_overrun),
        .tx_underrun (tx_underrun),
        .frame_err   (frame_err),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // Pulse counters, RX consumer capture and TX FIFO model, all away from the active edge.
    always @(negedge clk) begin
        if (tx_ready === 1'b1) begin
            n_rdy++;
            if (tx_q.size() > 0) void'(tx_q.pop_front());
        end
        if (tx_underrun === 1'b1) n_und++;
        if (rx_overrun === 1'b1) n_ovr++;
        if (frame_err === 1'b1) n_ferr++;
        if (rx_valid === 1'b1 && rx_ready === 1'b1) rx_got.push_back(rx_data);
        tx_valid = (tx_q.size() != 0);
        tx_data  = (tx_q.size() != 0) ? tx_q[0] : 8'h00;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Master shifts nbits of w MSB-first and collects MISO just before each rise.
    task automatic spi_bits(input logic [7:0] w, input int nbits, output logic [7:0] got);
        got = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            mosi = w[7-i];
            tick(H);
            got = {got[6:0], miso};
            if (i == 0) rdy_pre = n_rdy;
            sclk = 1'b1;
            tick(H);
            if (i == 0) rdy_post = n_rdy;
            sclk = 1'b0;
        end
    endtask

    task automatic cs_low();
        cs_n = 1'b0;
        tick(H);
    endtask

    task automatic cs_high();
        tick(H);
        cs_n = 1'b1;
        tick(H);
    endtask

    task automatic test_reset();
        rst = 1'b1; sclk = 1'b0; cs_n = 1'b1; mosi = 1'b0; rx_ready = 1'b0;
        tick(3);
        @(negedge clk);
        total++; if (miso !== 1'b1) begin bad++; $display("FAIL reset_miso got=%b want=1", miso); end
        total++; if (miso_oe !== 1'b0) begin bad++; $display("FAIL reset_miso_oe got=%b want=0", miso_oe); end
        total++; if (rx_data !== 8'h00) begin bad++; $display("FAIL reset_rx_data got=%h want=00", rx_data); end
        total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL reset_rx_valid got=%b want=0", rx_valid); end
        total++; if (tx_ready !== 1'b0) begin bad++; $display("FAIL reset_tx_ready got=%b want=0", tx_ready); end
        total++; if (rx_overrun !== 1'b0 || tx_underrun !== 1'b0 || frame_err !== 1'b0) begin
            bad++; $display("FAIL reset_pulses got=%b%b%b want=000", rx_overrun, tx_underrun, frame_err); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        tick(1);
        rst = 1'b0;
        tick(2);
    endtask

    task automatic test_single();
        logic [7:0] g;
        int b_rdy, b_und;
        tx_q.push_back(8'hA5);
        tick(2);
        b_rdy = n_rdy; b_und = n_und;
        cs_low();
        total++; if (busy !== 1'b1 || miso_oe !== 1'b1) begin
            bad++; $display("FAIL single_busy_oe got=%b%b want=11", busy, miso_oe); end
        spi_bits(8'h3C, 8, g);
        cs_high();
        total++; if (g !== 8'hA5) begin bad++; $display("FAIL single_miso got=%h want=a5", g); end
        total++; if (rx_valid !== 1'b1 || rx_data !== 8'h3C) begin
            bad++; $display("FAIL single_rx got=%b/%h want=1/3c", rx_valid, rx_data); end
        total++; if (rdy_pre - b_rdy != 0 || rdy_post - b_rdy != 1) begin
            bad++; $display("FAIL single_rdy_at_rise got=%0d/%0d want=0/1", rdy_pre - b_rdy, rdy_post - b_rdy); end
        total++; if (n_rdy - b_rdy != 1 || n_und - b_und != 0) begin
            bad++; $display("FAIL single_commit got=%0d/%0d want=1/0", n_rdy - b_rdy, n_und - b_und); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_busy_end got=%b want=0", busy); end
        rx_ready = 1'b1;
        tick(2);
        @(negedge clk);
        total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL single_drain got=%b want=0", rx_valid); end
        #1;
    endtask

    task automatic test_back_to_back();
        logic [7:0] g0, g1, g2;
        int b_rdy, b_ovr;
        tx_q = '{8'h10, 8'h11, 8'h12, 8'h13};
        rx_ready = 1'b1;
        tick(2);
        rx_got.delete();
        b_rdy = n_rdy; b_ovr = n_ovr;
        cs_low();
        spi_bits(8'h01, 8, g0);
        spi_bits(8'h02, 8, g1);
        spi_bits(8'h03, 8, g2);
        cs_high();
        total++; if (g0 !== 8'h10 || g1 !== 8'h11 || g2 !== 8'h12) begin
            bad++; $display("FAIL b2b_miso got=%h %h %h want=10 11 12", g0, g1, g2); end
        total++; if (rx_got.size() != 3) begin
            bad++; $display("FAIL b2b_rx_count got=%0d want=3", rx_got.size()); end
        else if (rx_got[0] !== 8'h01 || rx_got[1] !== 8'h02 || rx_got[2] !== 8'h03) begin
            bad++; $display("FAIL b2b_rx_order got=%h %h %h want=01 02 03", rx_got[0], rx_got[1], rx_got[2]); end
        total++; if (n_rdy - b_rdy != 3) begin bad++; $display("FAIL b2b_tx_ready got=%0d want=3", n_rdy - b_rdy); end
        total++; if (tx_q.size() != 1 || tx_valid !== 1'b1 || tx_data !== 8'h13) begin
            bad++; $display("FAIL b2b_trailing got=%0d/%h want=1/13", tx_q.size(), tx_data); end
        total++; if (n_ovr - b_ovr != 0) begin bad++; $display("FAIL b2b_overrun got=%0d want=0", n_ovr - b_ovr); end
        tx_q.delete();
        tick(2);
    endtask

    task automatic test_underrun();
        logic [7:0] g0, g1;
        int b_rdy, b_und;
        rx_ready = 1'b1;
        tick(2);
        rx_got.delete();
        b_rdy = n_rdy; b_und = n_und;
        cs_low();
        spi_bits(8'h55, 8, g0);
        spi_bits(8'hAA, 8, g1);
        cs_high();
        total++; if (g0 !== 8'hFF || g1 !== 8'hFF) begin
            bad++; $display("FAIL und_miso got=%h %h want=ff ff", g0, g1); end
        total++; if (n_und - b_und != 2) begin bad++; $display("FAIL und_count got=%0d want=2", n_und - b_und); end
        total++; if (n_rdy - b_rdy != 0) begin bad++; $display("FAIL und_tx_ready got=%0d want=0", n_rdy - b_rdy); end
        total++; if (rx_got.size() != 2 || rx_got[0] !== 8'h55 || rx_got[1] !== 8'hAA) begin
            bad++; $display("FAIL und_rx got=%0d words want=2 (55 aa)", rx_got.size()); end
    endtask

    task automatic test_overrun();
        logic [7:0] g;
        int b_ovr;
        rx_ready = 1'b0;
        tick(2);
        b_ovr = n_ovr;
        cs_low();
        spi_bits(8'h5A, 8, g);
        spi_bits(8'hC3, 8, g);
        cs_high();
        total++; if (rx_valid !== 1'b1 || rx_data !== 8'hC3) begin
            bad++; $display("FAIL ovr_rx got=%b/%h want=1/c3", rx_valid, rx_data); end
        total++; if (n_ovr - b_ovr != 1) begin bad++; $display("FAIL ovr_count got=%0d want=1", n_ovr - b_ovr); end
        rx_ready = 1'b1;
        tick(2);
        rx_ready = 1'b0;
        tick(1);
    endtask

    task automatic test_frame_err();
        logic [7:0] g;
        int b_ferr;
        rx_ready = 1'b0;
        b_ferr = n_ferr;
        cs_low();
        spi_bits(8'hB7, 5, g);
        tick(H);
        cs_n = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        total++; if (busy !== 1'b0 || miso_oe !== 1'b0) begin
            bad++; $display("FAIL ferr_idle got=%b%b want=00", busy, miso_oe); end
        tick(2);
        total++; if (n_ferr - b_ferr != 1) begin bad++; $display("FAIL ferr_count got=%0d want=1", n_ferr - b_ferr); end
        total++; if (rx_valid !== 1'b0 || rx_data !== 8'hC3) begin
            bad++; $display("FAIL ferr_rx got=%b/%h want=0/c3", rx_valid, rx_data); end
    endtask

    task automatic test_reset_mid();
        logic [7:0] g;
        int b_rdy, b_ferr;
        tx_q.push_back(8'h77);
        tick(2);
        b_rdy = n_rdy;
        cs_low();
        mosi = 1'b1;
        tick(2);
        rst = 1'b1;
        cs_n = 1'b1;
        tick(1);
        rst = 1'b0;
        @(negedge clk);
        total++; if (miso !== 1'b1 || miso_oe !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL rstmid_ctrl got=%b%b%b want=100", miso, miso_oe, busy); end
        total++; if (rx_valid !== 1'b0 || rx_data !== 8'h00) begin
            bad++; $display("FAIL rstmid_rx got=%b/%h want=0/00", rx_valid, rx_data); end
        total++; if (tx_ready !== 1'b0 || frame_err !== 1'b0 || tx_underrun !== 1'b0 || rx_overrun !== 1'b0) begin
            bad++; $display("FAIL rstmid_pulses got=%b%b%b%b want=0000", tx_ready, frame_err, tx_underrun, rx_overrun); end
        #1;
        tick(2);
        total++; if (n_rdy - b_rdy != 0 || tx_q.size() != 1) begin
            bad++; $display("FAIL rstmid_uncommitted got=%0d/%0d want=0/1", n_rdy - b_rdy, tx_q.size()); end
        rx_ready = 1'b1;
        rx_got.delete();
        b_ferr = n_ferr;
        cs_low();
        spi_bits(8'h99, 8, g);
        cs_high();
        total++; if (g !== 8'h77) begin bad++; $display("FAIL rstmid_next_miso got=%h want=77", g); end
        total++; if (n_rdy - b_rdy != 1 || n_ferr - b_ferr != 0) begin
            bad++; $display("FAIL rstmid_next_commit got=%0d/%0d want=1/0", n_rdy - b_rdy, n_ferr - b_ferr); end
        total++; if (rx_got.size() != 1 || rx_got[0] !== 8'h99) begin
            bad++; $display("FAIL rstmid_next_rx got=%0d words want=1 (99)", rx_got.size()); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_underrun();
        test_overrun();
        test_frame_err();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
